ntt_result_drain: RTL



---
 rtl/zk_ntt_pkg.sv | 21 ++
 rtl/mod_csub.sv | 31 +++
 rtl/ntt_result_drain.sv | 125 ++++++++++++
 3 files changed

// File: rtl/zk_ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zk_ntt_pkg
//  Description : Shared sizes and types for the 64-point NTT datapath
//                (ntt, rowcalc, ntt_result_drain).
//                NTT_N   - coefficients per transform
//                NTT_W   - coefficient width
//                NTT_MOD - field modulus (2^64 - 2^32 + 1)
//  Revision    : 1.0 - initial release
// ============================================================================
package zk_ntt_pkg;

    localparam int             NTT_N   = 64;
    localparam int             NTT_W   = 64;
    localparam logic [63:0]    NTT_MOD = 64'hFFFF_FFFF_0000_0001;

    typedef logic [NTT_W-1:0]         coeff_t;
    typedef logic [$clog2(NTT_N)-1:0] cidx_t;

endpackage
`default_nettype wire

// File: rtl/mod_csub.sv
`default_nettype none
// ============================================================================
//  Module      : mod_csub
//  Description : Combinational conditional subtraction of a modulus.
//                Brings an operand known to be < 2*MOD into [0, MOD) and
//                flags operands that violated that bound.
//  Ports       : i_raw     - W-bit operand
//                o_value   - (i_raw >= MOD) ? i_raw - MOD : i_raw
//                o_ge2mod  - i_raw >= 2*MOD, computed without widening
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_csub #(
    parameter int          W   = 64,
    parameter logic [W-1:0] MOD = '1
) (
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_value,
    output logic         o_ge2mod
);

    logic         w_ge_mod;
    logic [W-1:0] w_diff;

    assign w_ge_mod = (i_raw >= MOD);
    assign w_diff   = i_raw - MOD;
    assign o_value  = w_ge_mod ? w_diff : i_raw;
    // raw >= 2*MOD  <=>  raw >= MOD and (raw - MOD) >= MOD; avoids a W+1 bit compare.
    assign o_ge2mod = w_ge_mod && (w_diff >= MOD);

endmodule
`default_nettype wire

// File: rtl/ntt_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_result_drain
//  Description : Ping-pong capture of a parallel NTT result vector followed by
//                a reduced, one-coefficient-per-beat valid/ready stream.
//  Ports       : clk        - clock
//                rst        - asynchronous reset, active low
//                cap_valid  - one-cycle strobe, y_in holds a full result
//                y_in       - N raw coefficients
//                cap_ready  - a bank is free for the next capture
//                out_valid / out_ready - output handshake
//                out_data   - coefficient reduced into [0, MOD)
//                out_idx    - position of out_data in its transform
//                out_last   - final beat of a transform
//                overrun    - sticky, a capture was dropped (both banks full)
//                range_err  - sticky, an emitted raw value was >= 2*MOD
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_result_drain
    import zk_ntt_pkg::*;
#(
    parameter int           N   = NTT_N,
    parameter int           W   = NTT_W,
    parameter logic [W-1:0] MOD = W'(NTT_MOD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_valid,
    input  logic [W-1:0]         y_in [0:N-1],
    output logic                 cap_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 overrun,
    output logic                 range_err
);

    localparam int                   c_IDX_W = $clog2(N);
    localparam logic [c_IDX_W-1:0]   c_LAST  = c_IDX_W'(N - 1);

    // Buffer storage is never reset; r_full qualifies its contents.
    logic [W-1:0]       r_mem [0:1][0:N-1];
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_overrun;
    logic               r_range_err;

    logic               w_cap_ok;
    logic               w_cap_drop;
    logic               w_accept;
    logic               w_at_last;
    logic [W-1:0]       w_raw;
    logic               w_ge2mod;

    assign w_cap_ok   = cap_valid && !r_full[r_wr_bank];
    assign w_cap_drop = cap_valid &&  r_full[r_wr_bank];
    assign w_at_last  = (r_idx == c_LAST);
    assign w_accept   = r_full[r_rd_bank] && out_ready;
    assign w_raw      = r_mem[r_rd_bank][r_idx];

    mod_csub #(
        .W   (W),
        .MOD (MOD)
    ) u_csub (
        .i_raw    (w_raw),
        .o_value  (out_data),
        .o_ge2mod (w_ge2mod)
    );

    // Whole-vector write in the capture cycle. Capture only targets a free bank
    // and drain only reads a full one, so they never touch the same bank.
    always_ff @(posedge clk) begin
        if (w_cap_ok) begin
            for (int i = 0; i < N; i++) begin
                r_mem[r_wr_bank][i] <= y_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_idx       <= '0;
            r_overrun   <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            // Capture decides on the pre-edge r_full: a bank freed by the final
            // beat on this edge only becomes writable on the next one.
            if (w_cap_ok) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_cap_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                if (w_ge2mod) begin
                    r_range_err <= 1'b1;
                end
                if (w_at_last) begin
                    r_idx             <= '0;
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign cap_ready = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_idx   = r_idx;
    assign out_last  = r_full[r_rd_bank] && w_at_last;
    assign overrun   = r_overrun;
    assign range_err = r_range_err;

endmodule
`default_nettype wire
